cache_byte_valid_ctrl: RTL and testbench

CACHE_BYTE_VALID_CTRL -- requirements
Module: cache_byte_valid_ctrl

---
 rtl/cache_byte_valid_ctrl_if.sv | 38 +++
 rtl/cache_byte_valid_ctrl.sv | 141 ++++++++++++++
 tb/tb_cache_byte_valid_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_byte_valid_ctrl_if.sv
// Purpose: read/write/flush signal bundle for the byte-valid controller.
// Latency: none, wires only.
// Backpressure: none; the busy output tells the requester when writes are dropped.
interface cache_byte_valid_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WAYS       = 4,
    parameter int BYTES      = 4,
    parameter int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
);
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [WAY_W-1:0]        rd_way;
    logic                    rd_valid;
    logic [BYTES-1:0]        rd_mask;
    logic [WAYS*BYTES-1:0]   rd_all;
    logic                    rd_full;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [WAY_W-1:0]        wr_way;
    logic [BYTES-1:0]        wr_mask;
    logic                    wr_mode;
    logic                    flush_req;
    logic [WAYS-1:0]         flush_ways;
    logic                    busy;
    logic                    flush_done;

    modport slave (
        input  rd_en, rd_addr, rd_way, wr_en, wr_addr, wr_way, wr_mask, wr_mode,
               flush_req, flush_ways,
        output rd_valid, rd_mask, rd_all, rd_full, busy, flush_done
    );

    modport master (
        output rd_en, rd_addr, rd_way, wr_en, wr_addr, wr_way, wr_mask, wr_mode,
               flush_req, flush_ways,
        input  rd_valid, rd_mask, rd_all, rd_full, busy, flush_done
    );
endinterface

// File: rtl/cache_byte_valid_ctrl.sv
// Purpose: per-entry, per-way byte-valid bit store with merge/overwrite writes and bulk flush.
// Latency: reads return one cycle after rd_en (write-first); flush takes DEPTH+1 cycles.
// Backpressure: writes are dropped while busy; reads always complete but return 0 while busy.
module cache_byte_valid_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int WAYS       = 4,
    parameter int BYTES      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cache_byte_valid_ctrl_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int ENT_W = WAYS * BYTES;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WAYS-1:0]         ways_q, ways_d;
    logic                    busy_int, done_int;

    logic [ENT_W-1:0]        mem [DEPTH];
    logic [ENT_W-1:0]        wr_old, wr_new, rd_entry, clr_mask;
    logic                    wr_hit, wr_ok;
    logic [BYTES-1:0]        rd_sel;

    logic                    rd_valid_q, rd_full_q;
    logic [BYTES-1:0]        rd_mask_q;
    logic [ENT_W-1:0]        rd_all_q;

    // Flush FSM state; reset parks it in CLEAR with every way selected so the store self-initialises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ways_q  <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ways_q  <= ways_d;
        end
    end

    // Flush FSM next state and status outputs; counter holds at the last index rather than wrapping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ways_d   = ways_q;
        busy_int = 1'b1;
        done_int = 1'b0;
        case (state_q)
            IDLE: begin
                busy_int = 1'b0;
                if (bus.flush_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    ways_d  = bus.flush_ways;
                end
            end
            CLEAR: begin
                if (cnt_q == '1) state_d = DONE;
                else             cnt_d   = cnt_q + 1'b1;
            end
            DONE: begin
                done_int = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Post-write entry image; an out-of-range way matches no slice, so the write is dropped.
    always_comb begin
        wr_old = mem[bus.wr_addr];
        wr_new = wr_old;
        wr_hit = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (bus.wr_way == WAY_W'(w)) begin
                wr_hit = 1'b1;
                wr_new[w*BYTES +: BYTES] = bus.wr_mode ? bus.wr_mask
                                                       : (wr_old[w*BYTES +: BYTES] | bus.wr_mask);
            end
        end
        wr_ok = bus.wr_en && (state_q == IDLE) && wr_hit;
    end

    // Read source with write-first bypass; out-of-range way reads as zero.
    always_comb begin
        rd_entry = (wr_ok && (bus.wr_addr == bus.rd_addr)) ? wr_new : mem[bus.rd_addr];
        rd_sel   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (bus.rd_way == WAY_W'(w)) rd_sel = rd_entry[w*BYTES +: BYTES];
        end
    end

    // Expand the latched flush way selection into a per-bit clear mask.
    always_comb begin
        clr_mask = '0;
        for (int w = 0; w < WAYS; w++) begin
            clr_mask[w*BYTES +: BYTES] = {BYTES{ways_q[w]}};
        end
    end

    // Storage update: flush and writes never overlap because writes are accepted only in IDLE.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR)  mem[cnt_q]       <= mem[cnt_q] & ~clr_mask;
        else if (wr_ok)        mem[bus.wr_addr] <= wr_new;
    end

    // Registered read results; they hold between reads and read as zero while a flush runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_mask_q  <= '0;
            rd_all_q   <= '0;
            rd_full_q  <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                if (busy_int) begin
                    rd_mask_q <= '0;
                    rd_all_q  <= '0;
                    rd_full_q <= 1'b0;
                end else begin
                    rd_mask_q <= rd_sel;
                    rd_all_q  <= rd_entry;
                    rd_full_q <= &rd_sel;
                end
            end
        end
    end

    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_mask    = rd_mask_q;
    assign bus.rd_all     = rd_all_q;
    assign bus.rd_full    = rd_full_q;
    assign bus.busy       = busy_int;
    assign bus.flush_done = done_int;
endmodule

// File: tb/tb_cache_byte_valid_ctrl.sv
// Purpose: directed self-checking bench for cache_byte_valid_ctrl.
// Latency: inputs driven on falling edges, outputs sampled on the following falling edge.
// Backpressure: flush waits are bounded by a cycle budget.
module tb_cache_byte_valid_ctrl;
    localparam int AW     = 8;
    localparam int WAYS   = 4;
    localparam int BYTES  = 4;
    localparam int S_AW   = 2;
    localparam int S_WAYS = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   nbusy, ndone, done_at;

    cache_byte_valid_ctrl_if #(.ADDR_WIDTH(AW),   .WAYS(WAYS),   .BYTES(BYTES)) bus ();
    cache_byte_valid_ctrl_if #(.ADDR_WIDTH(S_AW), .WAYS(S_WAYS), .BYTES(BYTES)) sbus ();

    cache_byte_valid_ctrl #(.ADDR_WIDTH(AW), .WAYS(WAYS), .BYTES(BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Three-way instance: a 2-bit way field can carry the out-of-range value 3.
    cache_byte_valid_ctrl #(.ADDR_WIDTH(S_AW), .WAYS(S_WAYS), .BYTES(BYTES)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        bus.rd_en = 0;  bus.rd_addr = '0; bus.rd_way = '0;
        bus.wr_en = 0;  bus.wr_addr = '0; bus.wr_way = '0; bus.wr_mask = '0; bus.wr_mode = 0;
        bus.flush_req = 0; bus.flush_ways = '0;
        sbus.rd_en = 0; sbus.rd_addr = '0; sbus.rd_way = '0;
        sbus.wr_en = 0; sbus.wr_addr = '0; sbus.wr_way = '0; sbus.wr_mask = '0; sbus.wr_mode = 0;
        sbus.flush_req = 0; sbus.flush_ways = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [1:0] w, input logic [3:0] m, input logic mode);
        bus.wr_en = 1; bus.wr_addr = a; bus.wr_way = w; bus.wr_mask = m; bus.wr_mode = mode;
        @(negedge clk);
        bus.wr_en = 0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [1:0] w);
        bus.rd_en = 1; bus.rd_addr = a; bus.rd_way = w;
        @(negedge clk);
        bus.rd_en = 0;
    endtask

    // Counts busy cycles and flush_done pulses until busy drops, within a cycle budget.
    task automatic run_flush(output int nb, output int nd, output int dat);
        nb = 0; nd = 0; dat = 0;
        for (int i = 0; i < 600 && bus.busy; i++) begin
            nb++;
            if (bus.flush_done) begin
                nd++;
                dat = nb;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        clr_in();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",     64'(bus.busy),       64'd1);
        chk("rst_rd_valid", 64'(bus.rd_valid),   64'd0);
        chk("rst_rd_all",   64'(bus.rd_all),     64'd0);
        chk("rst_done",     64'(bus.flush_done), 64'd0);

        // Init flush after reset release.
        rst_n = 1'b1;
        run_flush(nbusy, ndone, done_at);
        chk("init_busy_cycles", 64'(nbusy),   64'd257);
        chk("init_done_pulses", 64'(ndone),   64'd1);
        chk("init_done_at",     64'(done_at), 64'd257);
        rd(8'd0, 2'd0);
        chk("init_rd_valid", 64'(bus.rd_valid), 64'd1);
        chk("init_rd_all0",  64'(bus.rd_all),   64'd0);
        rd(8'd200, 2'd3);
        chk("init_rd_all200", 64'(bus.rd_all),  64'd0);

        // Merge, merge, overwrite on addr 5 way 2.
        wr(8'd5, 2'd2, 4'b0011, 1'b0);
        wr(8'd5, 2'd2, 4'b1100, 1'b0);
        rd(8'd5, 2'd2);
        chk("merge_mask", 64'(bus.rd_mask), 64'hF);
        chk("merge_full", 64'(bus.rd_full), 64'd1);
        wr(8'd5, 2'd2, 4'b0001, 1'b1);
        rd(8'd5, 2'd2);
        chk("ovw_mask", 64'(bus.rd_mask), 64'h1);
        chk("ovw_full", 64'(bus.rd_full), 64'd0);
        chk("ovw_all",  64'(bus.rd_all),  64'h0100);

        // Same-cycle write and read to addr 7 way 1 returns the post-write value.
        bus.wr_en = 1; bus.wr_addr = 8'd7; bus.wr_way = 2'd1; bus.wr_mask = 4'b0101; bus.wr_mode = 0;
        bus.rd_en = 1; bus.rd_addr = 8'd7; bus.rd_way = 2'd1;
        @(negedge clk);
        bus.wr_en = 0; bus.rd_en = 0;
        chk("wf_valid", 64'(bus.rd_valid), 64'd1);
        chk("wf_mask",  64'(bus.rd_mask),  64'h5);
        chk("wf_all",   64'(bus.rd_all),   64'h0050);
        @(negedge clk);
        chk("hold_valid", 64'(bus.rd_valid), 64'd0);
        chk("hold_mask",  64'(bus.rd_mask),  64'h5);

        // Selective flush of ways 0 and 2.
        for (int w = 0; w < WAYS; w++) wr(8'd3, 2'(w), 4'hF, 1'b1);
        rd(8'd3, 2'd0);
        chk("fill_all", 64'(bus.rd_all), 64'hFFFF);
        bus.flush_req = 1; bus.flush_ways = 4'b0101;
        bus.wr_en = 1; bus.wr_addr = 8'd12; bus.wr_way = 2'd1; bus.wr_mask = 4'hF; bus.wr_mode = 0;
        @(negedge clk);
        bus.flush_req = 0; bus.flush_ways = '0; bus.wr_en = 0;
        chk("flush_busy", 64'(bus.busy), 64'd1);
        wr(8'd3, 2'd1, 4'h0, 1'b1);
        wr(8'd9, 2'd0, 4'hF, 1'b1);
        rd(8'd3, 2'd1);
        chk("busy_rd_valid", 64'(bus.rd_valid), 64'd1);
        chk("busy_rd_mask",  64'(bus.rd_mask),  64'h0);
        chk("busy_rd_all",   64'(bus.rd_all),   64'h0);
        bus.flush_req = 1; bus.flush_ways = 4'hF;
        @(negedge clk);
        bus.flush_req = 0; bus.flush_ways = '0;
        run_flush(nbusy, ndone, done_at);
        chk("flush_rest_cycles", 64'(nbusy),   64'd253);
        chk("flush_done_pulses", 64'(ndone),   64'd1);
        chk("flush_done_at",     64'(done_at), 64'd253);
        @(negedge clk);
        chk("no_requeue_busy", 64'(bus.busy), 64'd0);
        rd(8'd3, 2'd0);
        chk("flush_addr3", 64'(bus.rd_all), 64'hF0F0);
        rd(8'd9, 2'd0);
        chk("flush_addr9", 64'(bus.rd_all), 64'h0);
        rd(8'd5, 2'd2);
        chk("flush_addr5", 64'(bus.rd_all), 64'h0);
        rd(8'd7, 2'd1);
        chk("flush_addr7", 64'(bus.rd_all), 64'h0050);
        rd(8'd12, 2'd1);
        chk("flush_addr12", 64'(bus.rd_all), 64'h00F0);

        // Out-of-range way on the three-way instance.
        sbus.wr_en = 1; sbus.wr_addr = 2'd1; sbus.wr_way = 2'd0; sbus.wr_mask = 4'hA; sbus.wr_mode = 1;
        @(negedge clk);
        sbus.wr_way = 2'd3; sbus.wr_mask = 4'hF; sbus.wr_mode = 0;
        @(negedge clk);
        sbus.wr_en = 0;
        sbus.rd_en = 1; sbus.rd_addr = 2'd1; sbus.rd_way = 2'd0;
        @(negedge clk);
        chk("oor_wr_all",  64'(sbus.rd_all),  64'h00A);
        chk("oor_wr_mask", 64'(sbus.rd_mask), 64'hA);
        sbus.rd_way = 2'd3;
        @(negedge clk);
        sbus.rd_en = 0;
        chk("oor_rd_valid", 64'(sbus.rd_valid), 64'd1);
        chk("oor_rd_mask",  64'(sbus.rd_mask),  64'h0);
        chk("oor_rd_all",   64'(sbus.rd_all),   64'h00A);

        // Reset mid-flush at counter 100 aborts and restarts the init flush.
        rd(8'd7, 2'd1);
        bus.flush_req = 1; bus.flush_ways = 4'hF;
        @(negedge clk);
        bus.flush_req = 0; bus.flush_ways = '0;
        repeat (100) @(negedge clk);
        chk("pre_rst_hold_all", 64'(bus.rd_all), 64'h0050);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_all",   64'(bus.rd_all),     64'h0);
        chk("mid_rst_mask",  64'(bus.rd_mask),    64'h0);
        chk("mid_rst_valid", 64'(bus.rd_valid),   64'd0);
        chk("mid_rst_busy",  64'(bus.busy),       64'd1);
        chk("mid_rst_done",  64'(bus.flush_done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_flush(nbusy, ndone, done_at);
        chk("reinit_busy_cycles", 64'(nbusy), 64'd257);
        chk("reinit_done_pulses", 64'(ndone), 64'd1);
        rd(8'd7, 2'd1);
        chk("reinit_addr7", 64'(bus.rd_all), 64'h0);
        rd(8'd12, 2'd1);
        chk("reinit_addr12", 64'(bus.rd_all), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
